// File: rtl/impulse_mem_arbiter.sv
// Impulse-response memory arbiter: round-robin access for one write requester
// and one read requester onto a single RAM port, plus a zero-fill sequencer
// that clears locations 0..depth-1. Reads return data three cycles after the
// handshake (one registered command stage plus the RAM's two-cycle latency).
module impulse_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              audio_clk,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] depth,
  input  logic              clear_req,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              clearing,
  output logic              clear_done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic              last_grant;
  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W-1:0] fill_depth;
  logic              wr_hs;
  logic              rd_hs;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              vld_p1, vld_p2, vld_p3;
  logic              oor_p1, oor_p2, oor_p3;

  assign wr_hs       = wr_valid && wr_ready;
  assign rd_hs       = rd_valid && rd_ready;
  assign wr_in_range = wr_addr < depth;
  assign rd_in_range = rd_addr < depth;
  assign clearing    = (state == CLEAR);

  // Grant logic: a pending clear blocks both requesters; ties go to whoever
  // was not served last. Held low while reset is asserted.
  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    if (!rst_in && state == IDLE && !clear_req) begin
      if (wr_valid && (!rd_valid || last_grant == GRANT_RD)) begin
        wr_ready = 1'b1;
      end else if (rd_valid) begin
        rd_ready = 1'b1;
      end
    end
  end

  // Command stage: arbitration state, fill sequencer and the registered RAM port.
  // clear_done doubles as the "last fill cycle" marker that returns to IDLE.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      last_grant <= GRANT_RD;
      fill_addr  <= '0;
      fill_depth <= '0;
      clear_done <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      clear_done <= 1'b0;
      if (state == IDLE) begin
        if (clear_req) begin
          state      <= CLEAR;
          fill_depth <= depth;
          fill_addr  <= ONE;
          mem_addr   <= '0;
          mem_din    <= '0;
          clear_done <= (depth <= ONE);
          if (depth != '0) begin
            mem_en <= 1'b1;
            mem_we <= 1'b1;
          end
        end else if (wr_hs) begin
          last_grant <= GRANT_WR;
          mem_en     <= wr_in_range;
          mem_we     <= wr_in_range;
          mem_addr   <= wr_addr;
          mem_din    <= wr_data;
        end else if (rd_hs) begin
          last_grant <= GRANT_RD;
          mem_en     <= rd_in_range;
          mem_addr   <= rd_addr;
          mem_din    <= '0;
        end
      end else begin
        if (clear_done) begin
          state <= IDLE;
        end else begin
          mem_en     <= 1'b1;
          mem_we     <= 1'b1;
          mem_din    <= '0;
          mem_addr   <= fill_addr;
          fill_addr  <= fill_addr + ONE;
          clear_done <= (fill_addr == fill_depth - ONE);
        end
      end
    end
  end

  // Read return pipeline: tracks each accepted read and whether it was out of
  // range so the result can be forced to zero when it emerges.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      oor_p1 <= 1'b0;
      oor_p2 <= 1'b0;
      oor_p3 <= 1'b0;
    end else begin
      // p1: command on RAM port
      vld_p1 <= rd_hs;
      oor_p1 <= !rd_in_range;
      // p2: RAM internal stage
      vld_p2 <= vld_p1;
      oor_p2 <= oor_p1;
      // p3: RAM data on mem_dout
      vld_p3 <= vld_p2;
      oor_p3 <= oor_p2;
    end
  end

  assign rd_data_valid = vld_p3;
  assign rd_data       = (vld_p3 && !oor_p3) ? mem_dout : '0;

endmodule

// File: tb/tb_impulse_mem_arbiter.sv
// Bench for impulse_mem_arbiter: two-cycle RAM model, cycle-indexed
// expectation schedule derived from the arbitration/fill rules, directed
// scenarios with literal expectations, then randomized traffic.
module tb_impulse_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int NC     = 4096;

  logic              audio_clk = 1'b0;
  logic              rst_in;
  logic [ADDR_W-1:0] depth;
  logic              clear_req;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              clearing;
  logic              clear_done;

  impulse_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .depth(depth), .clear_req(clear_req),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .clearing(clearing), .clear_done(clear_done)
  );

  always #5 audio_clk = ~audio_clk;

  // RAM with two-cycle read latency; idle cycles feed noise into the pipe
  logic [DATA_W-1:0] ram [0:255];
  logic [DATA_W-1:0] r1, r2;
  always @(posedge audio_clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_din;
    if (mem_en && !mem_we) r1 <= ram[mem_addr];
    else r1 <= DATA_W'($urandom);
    r2 <= r1;
  end
  assign mem_dout = r2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] all_outs;
  assign all_outs = {17'd0, wr_ready, rd_ready, rd_data_valid, rd_data, mem_en,
                     mem_we, mem_addr, mem_din, clearing, clear_done};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: expected port activity scheduled by cycle number
  bit              s_en  [NC];
  bit              s_we  [NC];
  bit [ADDR_W-1:0] s_addr[NC];
  bit [DATA_W-1:0] s_din [NC];
  bit              s_rdv [NC];
  bit [DATA_W-1:0] s_rdd [NC];
  bit [DATA_W-1:0] golden[256];
  bit              last_was_rd = 1'b1;
  int              busy_until = -1;

  always @(negedge audio_clk) begin
    bit ew, er, busy;
    if (rst_in) begin
      chk("reset_outputs", all_outs, 64'd0);
      last_was_rd = 1'b1;
      busy_until  = -1;
      for (int i = cyc; i < NC; i++) begin
        s_en[i] = 0; s_we[i] = 0; s_rdv[i] = 0;
      end
    end else begin
      busy = (cyc <= busy_until);
      ew = 0;
      er = 0;
      if (!busy && !clear_req) begin
        if (wr_valid && (!rd_valid || last_was_rd)) ew = 1;
        else if (rd_valid) er = 1;
      end
      chk("wr_ready", wr_ready, ew);
      chk("rd_ready", rd_ready, er);
      chk("clearing", clearing, busy);
      chk("clear_done", clear_done, cyc == busy_until);
      chk("mem_en", mem_en, s_en[cyc]);
      chk("mem_we", mem_we, s_we[cyc]);
      if (s_en[cyc]) chk("mem_addr", mem_addr, s_addr[cyc]);
      if (s_we[cyc]) chk("mem_din", mem_din, s_din[cyc]);
      chk("rd_data_valid", rd_data_valid, s_rdv[cyc]);
      if (s_rdv[cyc]) chk("rd_data", rd_data, s_rdd[cyc]);
      if (!busy && clear_req) begin
        for (int k = 0; k < int'(depth); k++) begin
          s_en[cyc+1+k] = 1; s_we[cyc+1+k] = 1;
          s_addr[cyc+1+k] = ADDR_W'(k); s_din[cyc+1+k] = '0;
          golden[k] = '0;
        end
        busy_until = cyc + ((depth == 0) ? 1 : int'(depth));
      end
      if (ew) begin
        last_was_rd = 1'b0;
        if (wr_addr < depth) begin
          s_en[cyc+1] = 1; s_we[cyc+1] = 1;
          s_addr[cyc+1] = wr_addr; s_din[cyc+1] = wr_data;
          golden[wr_addr] = wr_data;
        end
      end
      if (er) begin
        last_was_rd = 1'b1;
        if (rd_addr < depth) begin
          s_en[cyc+1] = 1; s_we[cyc+1] = 0; s_addr[cyc+1] = rd_addr;
        end
        s_rdv[cyc+3] = 1;
        s_rdd[cyc+3] = (rd_addr < depth) ? golden[rd_addr] : '0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge audio_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1; depth = '0; clear_req = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    rd_valid = 0; rd_addr = '0;
    repeat (3) @(posedge audio_clk);
    #1 rst_in = 0;
    #1 chk("pre_edge_outputs", all_outs, 64'd0);

    // alternating grants under continuous contention, write first
    step();
    wr_valid = 1; rd_valid = 1; wr_addr = 8'd1; rd_addr = 8'd1; depth = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_wr", wr_ready, (i % 2) == 0);
      chk("rr_rd", rd_ready, (i % 2) == 1);
      step();
    end
    wr_valid = 0; rd_valid = 0;
    repeat (3) step();

    // initialise the RAM locations the bench uses
    depth = 8'd32; clear_req = 1;
    step();
    clear_req = 0;
    repeat (34) step();

    // clear priority over a pending write, ignored re-request, depth change mid-fill
    depth = 8'd5; wr_valid = 1; wr_addr = 8'd7; wr_data = 16'hAAAA; clear_req = 1;
    #1 chk("clear_blocks_grant", wr_ready, 1'b0);
    step();
    clear_req = 0; depth = 8'd2;
    for (int k = 0; k < 5; k++) begin
      chk("fill_we", mem_we, 1'b1);
      chk("fill_addr", mem_addr, k);
      chk("fill_din", mem_din, 0);
      chk("fill_done", clear_done, k == 4);
      clear_req = (k == 2);
      step();
    end
    clear_req = 0;
    #1;
    chk("resume_ready", wr_ready, 1'b1);
    chk("resume_clearing", clearing, 1'b0);
    chk("resume_done", clear_done, 1'b0);
    step();
    wr_valid = 0;

    // single write
    step();
    depth = 8'd8; wr_valid = 1; wr_addr = 8'd3; wr_data = 16'h1234;
    #1 chk("wr_grant", wr_ready, 1'b1);
    step();
    wr_valid = 0;
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 3);
    chk("wr_mem_din", mem_din, 16'h1234);
    wr_valid = 1; wr_addr = 8'd0; wr_data = 16'h1111;
    step();
    wr_addr = 8'd1; wr_data = 16'h2222;
    step();
    wr_valid = 0;

    // three back-to-back reads
    rd_valid = 1; rd_addr = 8'd0;
    step();
    rd_addr = 8'd1;
    step();
    rd_addr = 8'd2;
    step();
    rd_valid = 0;
    chk("rd0_valid", rd_data_valid, 1'b1); chk("rd0_data", rd_data, 16'h1111);
    step();
    chk("rd1_valid", rd_data_valid, 1'b1); chk("rd1_data", rd_data, 16'h2222);
    step();
    chk("rd2_valid", rd_data_valid, 1'b1); chk("rd2_data", rd_data, 16'h0000);
    step();
    chk("rd_end", rd_data_valid, 1'b0);

    // out-of-range write and read
    depth = 8'd4; wr_valid = 1; wr_addr = 8'd4; wr_data = 16'h5555;
    #1 chk("oor_wr_ready", wr_ready, 1'b1);
    step();
    wr_valid = 0;
    chk("oor_wr_en", mem_en, 1'b0);
    chk("oor_wr_we", mem_we, 1'b0);
    rd_valid = 1; rd_addr = 8'd9;
    step();
    rd_valid = 0;
    chk("oor_rd_en", mem_en, 1'b0);
    step();
    step();
    chk("oor_rd_valid", rd_data_valid, 1'b1);
    chk("oor_rd_data", rd_data, 16'h0000);
    step();

    // randomized traffic
    depth = 8'd10;
    for (int i = 0; i < 1500; i++) begin
      clear_req = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) depth = ADDR_W'($urandom_range(0, 20));
      wr_valid = 1'($urandom);
      rd_valid = 1'($urandom);
      wr_addr  = ADDR_W'($urandom_range(0, 23));
      rd_addr  = ADDR_W'($urandom_range(0, 23));
      wr_data  = DATA_W'($urandom);
      step();
    end
    clear_req = 0; wr_valid = 0; rd_valid = 0;
    repeat (25) step();

    // reset discards an in-flight read
    depth = 8'd8; rd_valid = 1; rd_addr = 8'd1;
    step();
    rd_valid = 0;
    #2 rst_in = 1;
    #1 chk("rst_async_outputs", all_outs, 64'd0);
    step();
    rst_in = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_discarded", rd_data_valid, 1'b0);
      step();
    end

    // reset in the middle of a fill
    depth = 8'd8; clear_req = 1;
    step();
    clear_req = 0;
    step();
    step();
    chk("fill_before_abort", mem_addr, 2);
    #1 rst_in = 1;
    #1 chk("abort_outputs", all_outs, 64'd0);
    repeat (2) step();
    rst_in = 0;
    step();
    wr_valid = 1; wr_addr = 8'd9;
    #1;
    chk("idle_after_abort", wr_ready, 1'b1);
    chk("no_clearing_after_abort", clearing, 1'b0);
    chk("no_done_after_abort", clear_done, 1'b0);
    step();
    wr_valid = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
